// File: rtl/vga_fb.sv
// vga_fb: parametrised VGA framebuffer controller.
//
// Pixel writes arrive over an AXI4-Lite write channel (AW/W/B), one pixel per
// 32-bit word at byte address index*4. The framebuffer holds FB_W x FB_H
// pixels (the active area shrunk by 2^SCALE on each axis) and is scanned out
// through a three-stage pipeline: counters, RAM read, output registers.
//
// Ports:
//   clk, rst                      system clock, synchronous active-low reset
//   awaddr/awprot/awvalid/awready AXI-Lite write address (awprot ignored)
//   wdata/wstrb/wvalid/wready     AXI-Lite write data
//   bresp/bvalid/bready           AXI-Lite write response (SLVERR out of range)
//   red/green/blue                colour channels, CHANNEL_BITS each
//   hsync/vsync                   sync outputs, active level SYNC_POL
//   irq                           one-clk vblank pulse
//
// Optional feature: define VGA_FB_VBLANK_IRQ_EN to generate irq; otherwise
// irq is tied low.

module vga_fb #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 24,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter bit SYNC_POL     = 1'b0,
    parameter int PIX_DIV      = 2,
    parameter int SCALE        = 1,
    parameter int CHANNEL_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [2:0]              awprot,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [STRB_WIDTH-1:0]   wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    output logic [CHANNEL_BITS-1:0] red,
    output logic [CHANNEL_BITS-1:0] green,
    output logic [CHANNEL_BITS-1:0] blue,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    irq
);

    localparam int H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_W        = H_ACTIVE >> SCALE;
    localparam int FB_H        = V_ACTIVE >> SCALE;
    localparam int FB_DEPTH    = FB_W * FB_H;
    localparam int COLOR_WIDTH = 3 * CHANNEL_BITS;
    localparam int IDX_W       = $clog2(FB_DEPTH);
    // +1 so the widths can also hold the totals themselves
    localparam int XW          = $clog2(H_TOTAL + 1);
    localparam int YW          = $clog2(V_TOTAL + 1);
    localparam int DW          = $clog2(PIX_DIV + 1);

    logic [DW-1:0]          divCnt;
    logic                   pixEn;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic                   active0, hs0, vs0;
    logic [IDX_W-1:0]       rdIdx;
    logic                   active1, hs1, vs1;
    logic [COLOR_WIDTH-1:0] rdData;
    logic [COLOR_WIDTH-1:0] rgbQ;
    logic [COLOR_WIDTH-1:0] mem [FB_DEPTH];

    logic                   readyEn;
    logic                   awFull, wFull;
    logic [ADDR_WIDTH-1:0]  awAddrH;
    logic [DATA_WIDTH-1:0]  wDataH;
    logic [STRB_WIDTH-1:0]  wStrbH;
    logic                   awHs, wHs, commit, inRange;
    logic [ADDR_WIDTH-1:0]  commitAddr;
    logic [DATA_WIDTH-1:0]  commitData;
    logic [STRB_WIDTH-1:0]  commitStrb;
    logic [IDX_W-1:0]       wrIdx;
    logic                   unused;

    assign pixEn = (divCnt == DW'(PIX_DIV - 1));

    // Stage 0: pixel divider and raster counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            divCnt <= '0;
            x      <= '0;
            y      <= '0;
        end else begin
            divCnt <= pixEn ? '0 : divCnt + 1'b1;
            if (pixEn) begin
                if (x == XW'(H_TOTAL - 1)) begin
                    x <= '0;
                    y <= (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
        end
    end

    // Read address is held at 0 in blanking so it never leaves the RAM range
    always_comb begin
        active0 = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
        hs0     = (x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC));
        vs0     = (y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC));
        rdIdx   = '0;
        if (active0)
            rdIdx = IDX_W'(32'(x >> SCALE) + 32'(y >> SCALE) * FB_W);
    end

    // Stage 1: delayed active/sync flags (RAM read data is in the RAM block)
    always_ff @(posedge clk) begin
        if (!rst) begin
            active1 <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
        end else if (pixEn) begin
            active1 <= active0;
            hs1     <= hs0;
            vs1     <= vs0;
        end
    end

    // Stage 2: output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgbQ  <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else if (pixEn) begin
            rgbQ  <= active1 ? rdData : '0;
            hsync <= hs1 ? SYNC_POL : ~SYNC_POL;
            vsync <= vs1 ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign red   = rgbQ[CHANNEL_BITS-1:0];
    assign green = rgbQ[2*CHANNEL_BITS-1:CHANNEL_BITS];
    assign blue  = rgbQ[3*CHANNEL_BITS-1:2*CHANNEL_BITS];

    // A write commits on the edge where the second half arrives, using the
    // live channel for whichever half is not yet held.
    assign awready = readyEn && !awFull;
    assign wready  = readyEn && !wFull;

    always_comb begin
        awHs       = awvalid && awready;
        wHs        = wvalid && wready;
        commitAddr = awFull ? awAddrH : awaddr;
        commitData = wFull ? wDataH : wdata;
        commitStrb = wFull ? wStrbH : wstrb;
        commit     = rst && (awFull || awHs) && (wFull || wHs) && !bvalid;
        inRange    = {2'b00, commitAddr[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(FB_DEPTH);
        wrIdx      = commitAddr[IDX_W+1:2];
    end

    // Holding registers stay full until the B handshake, which keeps the
    // ready signals low while a response is outstanding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            readyEn <= 1'b0;
            awFull  <= 1'b0;
            wFull   <= 1'b0;
            awAddrH <= '0;
            wDataH  <= '0;
            wStrbH  <= '0;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
        end else begin
            readyEn <= 1'b1;
            if (awHs) begin
                awFull  <= 1'b1;
                awAddrH <= awaddr;
            end
            if (wHs) begin
                wFull  <= 1'b1;
                wDataH <= wdata;
                wStrbH <= wstrb;
            end
            if (commit) begin
                bvalid <= 1'b1;
                bresp  <= inRange ? 2'b00 : 2'b10;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
                awFull <= 1'b0;
                wFull  <= 1'b0;
            end
        end
    end

    // Framebuffer RAM: byte-lane write, registered read (old data on collision)
    always_ff @(posedge clk) begin
        if (commit && inRange) begin
            for (int b = 0; b < COLOR_WIDTH; b++) begin
                if (commitStrb[b/8])
                    mem[wrIdx][b] <= commitData[b];
            end
        end
        if (pixEn)
            rdData <= mem[rdIdx];
    end

`ifdef VGA_FB_VBLANK_IRQ_EN
    // Pulse on the step from the last active line into (0, V_ACTIVE)
    always_ff @(posedge clk) begin
        if (!rst)
            irq <= 1'b0;
        else
            irq <= pixEn && (x == XW'(H_TOTAL - 1)) && (y == YW'(V_ACTIVE - 1));
    end
`else
    assign irq = 1'b0;
`endif

    assign unused = ^{awprot, commitAddr, commitData, commitStrb};

endmodule

// File: tb/tb_vga_fb.sv
// tb_vga_fb: directed bench for vga_fb on a small 16x8 raster
// (24x12 total, PIX_DIV=2, SCALE=1 -> 8x4 framebuffer, 576 clk per frame).

module tb_vga_fb;

    localparam int HA = 16, HF = 2, HS = 4, HB = 2;
    localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT * 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [3:0]  red, green, blue;
    logic        hsync, vsync, irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vga_fb #(
        .DATA_WIDTH(32), .ADDR_WIDTH(24), .STRB_WIDTH(4),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIX_DIV(2), .SCALE(1), .CHANNEL_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .irq(irq)
    );

    always #10 clk = ~clk;

    // Edges since reset release; pixel p of a frame is on the outputs
    // after edge 2*(p+2) (mod FRAME)
    always @(posedge clk) cyc <= rst ? cyc + 1 : 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitPixel(input int px, input int py);
        int t;
        int guard;
        t = 2 * (py * HT + px + 2);
        while (t <= cyc) t += FRAME;
        guard = 0;
        while (cyc != t && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        if (cyc != t) checkOutput("pixel wait timeout", 0, 1);
    endtask

    task automatic checkPixel(input string tag, input int px, input int py, input logic [11:0] exp);
        waitPixel(px, py);
        checkOutput(tag, {20'd0, blue, green, red}, {20'd0, exp});
    endtask

    // Simultaneous AW+W write, checks the response and releases it
    task automatic applyStimulus(input logic [23:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic [1:0] expResp);
        int guard;
        awaddr = addr; awvalid = 1'b1;
        wdata = data;  wstrb = strb; wvalid = 1'b1;
        guard = 0;
        while (!(awready && wready) && guard < 20) begin
            step();
            guard++;
        end
        if (!(awready && wready)) checkOutput("ready timeout", 0, 1);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        checkOutput("bvalid after write", {31'd0, bvalid}, 1);
        checkOutput("bresp", {30'd0, bresp}, {30'd0, expResp});
        checkOutput("awready while busy", {31'd0, awready}, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("bvalid cleared", {31'd0, bvalid}, 0);
        checkOutput("awready back", {31'd0, awready}, 1);
    endtask

    initial begin
        int hLow, vLow, irqHigh;
        rst = 1'b0; awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        repeat (4) step();
        checkOutput("reset rgb", {20'd0, blue, green, red}, 0);
        checkOutput("reset hsync", {31'd0, hsync}, 1);
        checkOutput("reset vsync", {31'd0, vsync}, 1);
        checkOutput("reset awready", {31'd0, awready}, 0);
        checkOutput("reset wready", {31'd0, wready}, 0);
        checkOutput("reset bvalid", {31'd0, bvalid}, 0);
        checkOutput("reset bresp", {30'd0, bresp}, 0);
        checkOutput("reset irq", {31'd0, irq}, 0);
        rst = 1'b1;
        step();
        checkOutput("awready after release", {31'd0, awready}, 1);
        checkOutput("wready after release", {31'd0, wready}, 1);

        // Basic writes and 2x upscaled readback
        applyStimulus(24'h4, 32'h123, 4'hF, 2'b00);
        applyStimulus(24'h0, 32'hABC, 4'hF, 2'b00);
        checkPixel("pix 0,0", 0, 0, 12'hABC);
        checkPixel("pix 1,0", 1, 0, 12'hABC);
        checkPixel("pix 2,0", 2, 0, 12'h123);
        checkPixel("pix 0,1", 0, 1, 12'hABC);
        checkPixel("pix 1,1", 1, 1, 12'hABC);
        checkPixel("hblank 16,0", 16, 0, 12'h000);
        checkPixel("vblank 0,8", 0, 8, 12'h000);

        // Range boundary: index 31 valid, index 32 rejected
        applyStimulus(24'h80, 32'h555, 4'hF, 2'b10);
        applyStimulus(24'h7C, 32'h7E1, 4'hF, 2'b00);
        checkPixel("pix 0,0 after slverr", 0, 0, 12'hABC);
        checkPixel("pix 14,6 last", 14, 6, 12'h7E1);
        checkPixel("pix 15,7 last", 15, 7, 12'h7E1);

        // Byte-lane strobes
        applyStimulus(24'h14, 32'h000, 4'hF, 2'b00);
        applyStimulus(24'h14, 32'hFFF, 4'h1, 2'b00);
        checkPixel("strobe lane0", 10, 0, 12'h0FF);
        applyStimulus(24'h14, 32'hA00, 4'h2, 2'b00);
        checkPixel("strobe lane1", 10, 0, 12'hAFF);

        // W three cycles ahead of AW, response held with bready low
        wdata = 32'h456; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checkOutput("early W wready", {31'd0, wready}, 0);
            checkOutput("early W bvalid", {31'd0, bvalid}, 0);
            checkOutput("early W awready", {31'd0, awready}, 1);
            step();
        end
        awaddr = 24'h8; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput("held bvalid", {31'd0, bvalid}, 1);
            checkOutput("held bresp", {30'd0, bresp}, 0);
            checkOutput("held awready", {31'd0, awready}, 0);
            checkOutput("held wready", {31'd0, wready}, 0);
            step();
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("late bvalid cleared", {31'd0, bvalid}, 0);
        checkOutput("late wready back", {31'd0, wready}, 1);
        checkPixel("pix 4,0 late AW", 4, 0, 12'h456);

        // Sync placement relative to pixels
        waitPixel(17, 0); checkOutput("hsync 17", {31'd0, hsync}, 1);
        waitPixel(18, 0); checkOutput("hsync 18", {31'd0, hsync}, 0);
        waitPixel(21, 0); checkOutput("hsync 21", {31'd0, hsync}, 0);
        waitPixel(22, 0); checkOutput("hsync 22", {31'd0, hsync}, 1);
        waitPixel(0, 8);  checkOutput("vsync line 8", {31'd0, vsync}, 1);
        waitPixel(0, 9);  checkOutput("vsync line 9", {31'd0, vsync}, 0);
        waitPixel(23, 10); checkOutput("vsync line 10", {31'd0, vsync}, 0);
        waitPixel(0, 11); checkOutput("vsync line 11", {31'd0, vsync}, 1);

        // One whole frame of sync/irq activity
        hLow = 0; vLow = 0; irqHigh = 0;
        for (int i = 0; i < FRAME; i++) begin
            step();
            if (hsync == 1'b0) hLow++;
            if (vsync == 1'b0) vLow++;
            if (irq == 1'b1) irqHigh++;
        end
        checkOutput("hsync low clk per frame", hLow, 96);
        checkOutput("vsync low clk per frame", vLow, 96);
`ifdef VGA_FB_VBLANK_IRQ_EN
        checkOutput("irq clk per frame", irqHigh, 1);
`else
        checkOutput("irq clk per frame", irqHigh, 0);
`endif

        // Reset with a W held: it must be dropped
        wdata = 32'h999; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        checkOutput("pre-reset wready", {31'd0, wready}, 0);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        checkOutput("post-reset wready", {31'd0, wready}, 1);
        checkOutput("post-reset bvalid", {31'd0, bvalid}, 0);
        awaddr = 24'h8; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        checkOutput("AW alone no bvalid", {31'd0, bvalid}, 0);
        checkOutput("AW alone awready", {31'd0, awready}, 0);
        wdata = 32'h789; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        checkOutput("late W bvalid", {31'd0, bvalid}, 1);
        checkOutput("late W bresp", {30'd0, bresp}, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        checkOutput("late W bvalid cleared", {31'd0, bvalid}, 0);
        checkPixel("pix 4,0 after reset", 4, 0, 12'h789);
        checkPixel("pix 0,0 kept over reset", 0, 0, 12'hABC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
